// File: rtl/bulls_cows_core.sv
// bulls_cows_core: Bulls-and-Cows scorer. Scores one guess digit per cycle against a latched secret.
// Define BC_DUPCHK_EN to reject loads or guesses with repeated digits through an out_err pulse.
module bulls_cows_core #(
  parameter int NDIG    = 4,
  parameter int DW      = 4,
  parameter int MAX_TRY = 8
) (
  input  logic                         in_clk,
  input  logic                         in_restart_n,
  input  logic                         in_loadtest,
  input  logic                         in_enter,
  input  logic [NDIG*DW-1:0]           in_digits,
  output logic [$clog2(NDIG+1)-1:0]    out_Anum,
  output logic [$clog2(NDIG+1)-1:0]    out_Bnum,
  output logic [2:0]                   out_state,
  output logic                         out_valid,
  output logic [$clog2(MAX_TRY+1)-1:0] out_tries,
  output logic                         out_err
);
  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(MAX_TRY + 1);
  localparam int IW = $clog2(NDIG);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    CMP  = 3'd2,
    DONE = 3'd3,
    WIN  = 3'd4,
    LOSE = 3'd5
  } state_e;

  state_e              state_q;
  logic [NDIG*DW-1:0]  secret_q, guess_q;
  logic [IW-1:0]       idx_q;
  logic [CW-1:0]       a_q, b_q, a_d, b_d, anum_q, bnum_q;
  logic [TW-1:0]       tries_q;
  logic                valid_q, err_q;
  logic [DW-1:0]       g_dig;
  logic                hit_a, hit_b;
  logic                rej;

`ifdef BC_DUPCHK_EN
  function automatic logic has_dup(input logic [NDIG*DW-1:0] v);
    has_dup = 1'b0;
    for (int i = 0; i < NDIG; i++)
      for (int j = i + 1; j < NDIG; j++)
        if (v[i*DW +: DW] == v[j*DW +: DW]) has_dup = 1'b1;
  endfunction
  assign rej = has_dup(in_digits);
`else
  assign rej = 1'b0;
`endif

  // Score the guess digit at idx_q: exact position hit (A) or present elsewhere in the secret (B).
  always_comb begin
    g_dig = guess_q[int'(idx_q)*DW +: DW];
    hit_a = g_dig == secret_q[int'(idx_q)*DW +: DW];
    hit_b = 1'b0;
    for (int j = 0; j < NDIG; j++)
      if (j != int'(idx_q) && secret_q[j*DW +: DW] == g_dig) hit_b = 1'b1;
    a_d = a_q + CW'(hit_a);
    b_d = b_q + CW'(!hit_a && hit_b);
  end

  // Game FSM with registered outputs; load beats enter, pulses self-clear every cycle.
  always_ff @(posedge in_clk or negedge in_restart_n) begin
    if (!in_restart_n) begin
      state_q  <= IDLE;
      secret_q <= '0;
      guess_q  <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      anum_q   <= '0;
      bnum_q   <= '0;
      tries_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE, WAIT, WIN, LOSE: begin
          if (in_loadtest) begin
            if (rej) err_q <= 1'b1;
            else begin
              secret_q <= in_digits;
              tries_q  <= '0;
              anum_q   <= '0;
              bnum_q   <= '0;
              state_q  <= WAIT;
            end
          end else if (state_q == WAIT && in_enter) begin
            if (rej) err_q <= 1'b1;
            else begin
              guess_q <= in_digits;
              tries_q <= tries_q + 1'b1;
              a_q     <= '0;
              b_q     <= '0;
              idx_q   <= '0;
              state_q <= CMP;
            end
          end
        end
        CMP: begin
          a_q   <= a_d;
          b_q   <= b_d;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(NDIG - 1)) begin
            anum_q  <= a_d;
            bnum_q  <= b_d;
            valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: state_q <= anum_q == CW'(NDIG) ? WIN : tries_q == TW'(MAX_TRY) ? LOSE : WAIT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_Anum  = anum_q;
  assign out_Bnum  = bnum_q;
  assign out_state = state_q;
  assign out_valid = valid_q;
  assign out_tries = tries_q;
  assign out_err   = err_q;
endmodule

// File: tb/tb_bulls_cows_core.sv
// tb_bulls_cows_core: scoreboard bench for bulls_cows_core at NDIG=4, DW=4, MAX_TRY=8.
module tb_bulls_cows_core;
  localparam int NDIG = 4, DW = 4, MAX_TRY = 8;

  logic        in_clk, in_restart_n, in_loadtest, in_enter;
  logic [15:0] in_digits;
  logic [2:0]  out_Anum, out_Bnum, out_state;
  logic        out_valid, out_err;
  logic [3:0]  out_tries;

  typedef struct {int a; int b; int t;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0, n_bad = 0, vcount = 0;
  logic [15:0] m_secret;
  int m_tries;

  bulls_cows_core #(.NDIG(NDIG), .DW(DW), .MAX_TRY(MAX_TRY)) dut (
    .in_clk(in_clk), .in_restart_n(in_restart_n), .in_loadtest(in_loadtest),
    .in_enter(in_enter), .in_digits(in_digits), .out_Anum(out_Anum),
    .out_Bnum(out_Bnum), .out_state(out_state), .out_valid(out_valid),
    .out_tries(out_tries), .out_err(out_err));

  initial begin
    in_clk = 1'b0;
    forever #5 in_clk = ~in_clk;
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] pack(input int d0, input int d1, input int d2, input int d3);
    pack = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
  endfunction

  function automatic exp_t score(input logic [15:0] s, input logic [15:0] g, input int t);
    exp_t r;
    r.a = 0; r.b = 0; r.t = t;
    for (int i = 0; i < NDIG; i++) begin
      if (g[i*DW +: DW] == s[i*DW +: DW]) r.a++;
      else begin
        bit f = 0;
        for (int j = 0; j < NDIG; j++) if (j != i && g[i*DW +: DW] == s[j*DW +: DW]) f = 1;
        if (f) r.b++;
      end
    end
    return r;
  endfunction

  always @(negedge in_clk) begin
    if (in_restart_n && out_valid) begin
      vcount++;
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("A", int'(out_Anum), mon_e.a);
        chk("B", int'(out_Bnum), mon_e.b);
        chk("tries", int'(out_tries), mon_e.t);
      end
    end
  end

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    in_digits = v; in_loadtest = 1'b1;
    tick();
    in_loadtest = 1'b0;
    m_secret = v; m_tries = 0;
  endtask

  task automatic enter(input logic [15:0] v);
    int n = 0;
    m_tries++;
    q.push_back(score(m_secret, v, m_tries));
    in_digits = v; in_enter = 1'b1;
    tick();
    in_enter = 1'b0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n + 1, NDIG + 1);
    tick();
  endtask

  initial begin
    int v0;
    in_restart_n = 1'b0; in_loadtest = 1'b0; in_enter = 1'b0; in_digits = '0;
    m_secret = '0; m_tries = 0;
    #12;
    chk("rst_state", int'(out_state), 0);
    chk("rst_A", int'(out_Anum), 0);
    chk("rst_B", int'(out_Bnum), 0);
    chk("rst_tries", int'(out_tries), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_err", int'(out_err), 0);
    in_restart_n = 1'b1;
    tick();
    chk("idle_hold", int'(out_state), 0);

    load(pack(2, 3, 4, 5));
    chk("load_state", int'(out_state), 1);
    chk("load_tries", int'(out_tries), 0);
    enter(pack(2, 3, 4, 5));
    chk("win_state", int'(out_state), 4);
    tick();
    chk("win_hold", int'(out_state), 4);

    load(pack(2, 3, 4, 5));
    enter(pack(5, 4, 3, 2));
    chk("wait1", int'(out_state), 1);
    enter(pack(5, 4, 2, 3));
    chk("wait2", int'(out_state), 1);
    enter(pack(5, 4, 2, 8));
    chk("wait3", int'(out_state), 1);
    chk("tries3", int'(out_tries), 3);

    load(pack(2, 3, 4, 5));
    for (int k = 0; k < MAX_TRY; k++) begin
      enter(pack(6, 7, 8, 9));
      if (k < MAX_TRY - 1) chk("miss_wait", int'(out_state), 1);
    end
    chk("lose_state", int'(out_state), 5);
    chk("lose_tries", int'(out_tries), MAX_TRY);
    v0 = vcount;
    in_digits = pack(2, 3, 4, 5); in_enter = 1'b1;
    tick();
    in_enter = 1'b0;
    repeat (7) tick();
    chk("ninth_state", int'(out_state), 5);
    chk("ninth_tries", int'(out_tries), MAX_TRY);
    chk("ninth_novalid", vcount, v0);
    load(pack(2, 3, 4, 5));
    chk("reload_state", int'(out_state), 1);
    chk("reload_tries", int'(out_tries), 0);

    v0 = vcount;
    in_digits = pack(2, 3, 4, 5); in_enter = 1'b1;
    tick();
    in_enter = 1'b0;
    tick();
    tick();
    chk("mid_cmp", int'(out_state), 2);
    in_restart_n = 1'b0;
    #1;
    chk("abort_state", int'(out_state), 0);
    chk("abort_A", int'(out_Anum), 0);
    chk("abort_B", int'(out_Bnum), 0);
    chk("abort_tries", int'(out_tries), 0);
    chk("abort_valid", int'(out_valid), 0);
    repeat (6) tick();
    in_restart_n = 1'b1;
    tick();
    repeat (6) tick();
    chk("abort_novalid", vcount, v0);
    chk("abort_idle", int'(out_state), 0);
    m_secret = '0; m_tries = 0;

    load(pack(2, 3, 4, 5));
`ifdef BC_DUPCHK_EN
    in_digits = pack(1, 1, 2, 3); in_enter = 1'b1;
    tick();
    in_enter = 1'b0;
    chk("dup_err", int'(out_err), 1);
    chk("dup_state", int'(out_state), 1);
    chk("dup_tries", int'(out_tries), 0);
    tick();
    chk("dup_err_clr", int'(out_err), 0);
`else
    enter(pack(1, 1, 2, 3));
    chk("dup_state", int'(out_state), 1);
    chk("dup_err", int'(out_err), 0);
`endif

    v0 = vcount;
    in_digits = pack(6, 7, 8, 9); in_loadtest = 1'b1; in_enter = 1'b1;
    tick();
    in_loadtest = 1'b0; in_enter = 1'b0;
    m_secret = pack(6, 7, 8, 9); m_tries = 0;
    chk("both_state", int'(out_state), 1);
    chk("both_tries", int'(out_tries), 0);
    repeat (7) tick();
    chk("both_state_hold", int'(out_state), 1);
    chk("both_novalid", vcount, v0);
    enter(pack(6, 7, 8, 9));
    chk("both_win", int'(out_state), 4);

    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bulls_cows_core.md
BULLS_COWS_CORE -- requirements
Module: bulls_cows_core

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of digits per secret and per guess (2..8).
REQ-002 SHALL have parameter DW, default 4: bits per digit.
REQ-003 SHALL have parameter MAX_TRY, default 8: guesses allowed per secret (1..15).
REQ-004 in_clk  input  1: single clock, rising-edge.
REQ-005 in_restart_n  input  1: reset, asynchronous, active-low.
REQ-006 in_loadtest  input  1: load the value on in_digits as the secret.
REQ-007 in_enter  input  1: submit the value on in_digits as a guess.
REQ-008 in_digits  input  NDIG*DW: digit k at [k*DW +: DW].
REQ-009 out_Anum  output  $clog2(NDIG+1): count of right digits in the right position (A).
REQ-010 out_Bnum  output  $clog2(NDIG+1): count of right digits in the wrong position (B).
REQ-011 out_state  output  3: FSM state encoding.
REQ-012 out_valid  output  1: one-cycle pulse when a score is ready.
REQ-013 out_tries  output  $clog2(MAX_TRY+1): guesses accepted against the current secret.
REQ-014 out_err  output  1: one-cycle duplicate-digit reject pulse (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE=0, WAIT=1, CMP=2, DONE=3, WIN=4, LOSE=5; encodings 6 and 7 SHALL recover to IDLE on the next edge.
REQ-016 in_loadtest sampled high in IDLE, WAIT, WIN or LOSE SHALL latch the secret, clear out_tries, clear A/B, and enter WAIT.
REQ-017 in_loadtest SHALL be ignored in CMP and DONE.
REQ-018 in_enter sampled high in WAIT SHALL latch the guess, increment out_tries, clear the A/B accumulators, set index i=0, and enter CMP.
REQ-019 in_enter SHALL be ignored in every state other than WAIT.
REQ-020 If in_loadtest and in_enter are both high in WAIT, in_loadtest SHALL take priority and in_enter SHALL be ignored.
REQ-021 CMP SHALL score one guess digit per cycle, i=0..NDIG-1.
REQ-022 In CMP, guess[i]==secret[i] SHALL increment A; otherwise, guess[i] equal to any secret[j] with j!=i SHALL increment B.
REQ-023 On the edge that processes i=NDIG-1, the FSM SHALL enter DONE.
REQ-024 out_valid SHALL be 1 for exactly the one cycle spent in DONE; latency is NDIG+1 edges from the edge accepting in_enter.
REQ-025 From DONE the FSM SHALL go to WIN if A==NDIG; else to LOSE if out_tries==MAX_TRY; else to WAIT.
REQ-026 out_Anum and out_Bnum SHALL update at DONE entry and hold until the next accepted guess, reload, or reset.
REQ-027 WIN and LOSE SHALL hold until in_loadtest.
REQ-028 out_tries SHALL never exceed MAX_TRY.

Reset
REQ-029 in_restart_n low SHALL asynchronously force IDLE, with the secret, guess, i, out_Anum, out_Bnum, out_tries, out_valid and out_err all 0.
REQ-030 Reset asserted mid-CMP SHALL abort scoring with no out_valid pulse.
REQ-031 Deassertion SHALL take effect at the first rising edge after in_restart_n goes high.

Configuration
REQ-032 Macro BC_DUPCHK_EN SHALL control duplicate-digit checking.
REQ-033 With BC_DUPCHK_EN defined, a load or guess containing any repeated digit SHALL be rejected: out_err pulses high for 1 cycle; state, secret and out_tries are unchanged.
REQ-034 Without BC_DUPCHK_EN, out_err SHALL be tied 0, and duplicate digits SHALL be accepted and scored per REQ-022.

Verification (NDIG=4, DW=4, MAX_TRY=8; digit order d0,d1,d2,d3)
REQ-035 Load secret 2,3,4,5, then guess 2,3,4,5 -> out_valid high on the 5th edge after enter, A=4, B=0, tries=1, then WIN.
REQ-036 Secret 2,3,4,5: guess 5,4,3,2 -> A=0, B=4; guess 5,4,2,3 -> A=0, B=4; guess 5,4,2,8 -> A=0, B=3; state returns to WAIT after each, tries=3.
REQ-037 Eight guesses 6,7,8,9 -> each A=0, B=0; after the 8th, LOSE with tries=8; a 9th enter is ignored; in_loadtest -> WAIT with tries=0.
REQ-038 Assert in_restart_n low during CMP (i=2) -> immediate IDLE, all outputs 0, no out_valid pulse.
REQ-039 Guess 1,1,2,3 against 2,3,4,5 -> with BC_DUPCHK_EN: out_err pulses for 1 cycle, tries unchanged, WAIT held; without BC_DUPCHK_EN: A=0, B=2.
REQ-040 Assert in_loadtest and in_enter together in WAIT -> new secret latched, tries=0, no CMP entry, no out_valid.
